// File: rtl/nes_dma_pkg.sv
// Shared types and defaults for the NES sprite DMA path.
// Also used by the APU DMA blocks and their benches.
package nes_dma_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HALT  = 3'd1,
        ALIGN = 3'd2,
        READ  = 3'd3,
        WRITE = 3'd4
    } dma_state_e;

    localparam logic [15:0] DMA_REG_ADDR_DFLT  = 16'h4014;
    localparam logic [15:0] OAM_DATA_ADDR_DFLT = 16'h2004;
    localparam int          BYTE_COUNT         = 256;
    localparam logic [7:0]  IDX_LAST           = 8'(BYTE_COUNT - 1);
    localparam int          CPU_CYC_W          = 16;

endpackage

// File: rtl/cpu_cycle_parity.sv
// Even/odd CPU cycle tracker.
// Flips on every CPU cycle boundary; 0 marks an even cycle.
module cpu_cycle_parity (
    input  logic clk,
    input  logic rst,
    input  logic cpu_ce,
    output logic parity
);

    logic r_parity;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_parity <= 1'b0;
        else if (cpu_ce)
            r_parity <= ~r_parity;
    end

    assign parity = r_parity;

endmodule

// File: rtl/oam_dma_ctrl.sv
// Sprite OAM DMA: halts the CPU on a $4014 write and copies
// one 256-byte page into $2004 with alternating read/write cycles.
module oam_dma_ctrl
    import nes_dma_pkg::*;
#(
    parameter logic [15:0] DMA_REG_ADDR  = DMA_REG_ADDR_DFLT,
    parameter logic [15:0] OAM_DATA_ADDR = OAM_DATA_ADDR_DFLT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_ce,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    input  logic        cpu_rw,
    output logic        cpu_rdy,
    output logic        dma_active,
    output logic [15:0] dma_addr,
    output logic        dma_rw,
    output logic [7:0]  dma_wdata,
    input  logic [7:0]  dma_rdata
);

    dma_state_e  r_state;
    dma_state_e  w_next;
    logic        w_parity;
    logic        w_hit;
    logic        w_last;
    logic [7:0]  r_page;
    logic [7:0]  r_idx;
    logic [7:0]  r_latch;
    logic [15:0] r_hold_addr;

    cpu_cycle_parity u_parity (
        .clk    (clk),
        .rst    (rst),
        .cpu_ce (cpu_ce),
        .parity (w_parity)
    );

    assign w_hit  = !cpu_rw && (cpu_addr == DMA_REG_ADDR);
    assign w_last = (r_idx == IDX_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= IDLE;
        else if (cpu_ce)
            r_state <= w_next;
    end

    // Page, index and read latch only move on CPU cycle boundaries.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_page      <= 8'h00;
            r_idx       <= 8'h00;
            r_latch     <= 8'h00;
            r_hold_addr <= 16'h0000;
        end else if (cpu_ce) begin
            if (r_state == IDLE && w_hit) begin
                r_page      <= cpu_wdata;
                r_idx       <= 8'h00;
                r_hold_addr <= cpu_addr;
            end
            if (r_state == READ)
                r_latch <= dma_rdata;
            if (r_state == WRITE)
                r_idx <= r_idx + 8'h01;
        end
    end

    always_comb begin
        w_next     = r_state;
        cpu_rdy    = 1'b1;
        dma_active = 1'b0;
        dma_addr   = 16'h0000;
        dma_rw     = 1'b1;
        dma_wdata  = 8'h00;
        unique case (r_state)
            IDLE: begin
                if (w_hit)
                    w_next = HALT;
            end
            HALT: begin
                cpu_rdy    = 1'b0;
                dma_active = 1'b1;
                dma_addr   = r_hold_addr;
                // An even HALT is followed by an odd cycle: pad it.
                w_next     = w_parity ? READ : ALIGN;
            end
            ALIGN: begin
                cpu_rdy    = 1'b0;
                dma_active = 1'b1;
                dma_addr   = r_hold_addr;
                w_next     = READ;
            end
            READ: begin
                cpu_rdy    = 1'b0;
                dma_active = 1'b1;
                dma_addr   = {r_page, r_idx};
                w_next     = WRITE;
            end
            WRITE: begin
                cpu_rdy    = 1'b0;
                dma_active = 1'b1;
                dma_addr   = OAM_DATA_ADDR;
                dma_rw     = 1'b0;
                dma_wdata  = r_latch;
                w_next     = w_last ? IDLE : READ;
            end
            default: w_next = IDLE;
        endcase
    end

endmodule

// File: doc/oam_dma_ctrl.md
Name: oam_dma_ctrl

Overview:
Sprite OAM DMA controller for the NES top level. It watches CPU writes to $4014 and halts the 6502 through RDY. It then takes the CPU bus and copies 256 bytes from page {data,8'h00} to the PPU OAM port ($2004), using alternating read/write CPU cycles. It sits between the CPU core and the system bus mux, and runs on the system clock gated by the CPU cycle enable.

Parameters:
DMA_REG_ADDR, 16'h4014, CPU address that triggers DMA
OAM_DATA_ADDR, 16'h2004, destination address for every write
BYTE_COUNT, 256, bytes per transfer (index width fixed at 8 bits)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
cpu_ce  input  1  one-clk pulse marking the end of each CPU cycle; all state advances only on clk edges where cpu_ce=1
cpu_addr  input  16  CPU address bus
cpu_wdata  input  8  CPU write data
cpu_rw  input  1  1=read, 0=write
cpu_rdy  output  1  RDY to CPU; 0 halts the CPU
dma_active  output  1  1 = bus mux selects DMA master signals
dma_addr  output  16  DMA bus address
dma_rw  output  1  DMA direction, 1=read, 0=write
dma_wdata  output  8  DMA write data
dma_rdata  input  8  bus read data, valid at the cpu_ce edge ending a read cycle

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous and active-high.
- Reset values: state=IDLE, cpu_rdy=1, dma_active=0, dma_addr=16'h0000, dma_rw=1, dma_wdata=8'h00, page=0, idx=0, parity=0, latch=0.
- parity toggles on every cpu_ce, in all states. Even cycle means parity=0 during that cycle.
- Trigger: on a cpu_ce edge in IDLE with cpu_rw=0 and cpu_addr==DMA_REG_ADDR:
  - page <= cpu_wdata, idx <= 0, state <= HALT.
  - cpu_rdy and dma_active are registered and go 0/1 on that same edge.
- HALT (1 CPU cycle): dma_addr = cpu_addr pass-through value latched at trigger, dma_rw=1 (dummy read). Next state:
  - ALIGN if the upcoming cycle is odd (parity after toggle = 1).
  - READ otherwise.
- ALIGN (1 CPU cycle): dummy read, same address as HALT, then READ.
- READ (even cycle): dma_addr={page,idx}, dma_rw=1. At the ending cpu_ce, latch <= dma_rdata; go to WRITE.
- WRITE (odd cycle): dma_addr=OAM_DATA_ADDR, dma_rw=0, dma_wdata=latch. At the ending cpu_ce:
  - if idx==8'hFF: go to IDLE, set cpu_rdy=1 and dma_active=0.
  - else: idx <= idx+1, go to READ.
- Latency from trigger edge to release: 513 CPU cycles when the trigger lands on an edge where the next cycle is odd, i.e. HALT is odd and no ALIGN; 514 otherwise.
- idx wraps only at completion and never advances past 8'hFF. page is not incremented, so the source stays within one page.
- Writes to DMA_REG_ADDR while not IDLE are ignored; the CPU is halted, so they can only come from a bench.
- Writes to other addresses never trigger.
- Between cpu_ce pulses all outputs hold.
- Reset mid-transfer: immediate return to reset values. The partial OAM contents are left as they are, and there is no resume.
- When dma_active=0, the dma_* outputs sit at their reset values.

Decomposition:
- Package nes_dma_pkg holds:
  - state encoding: IDLE, HALT, ALIGN, READ, WRITE (3-bit);
  - the DMA_REG_ADDR and OAM_DATA_ADDR defaults;
  - the CPU-cycle counter width used by benches.
- One sub-module is natural: cpu_cycle_parity (clk, rst, cpu_ce -> parity). It is reusable by the APU frame counter and DMC DMA.

Test Plan:
- Reset check: hold rst for 5 clk -> cpu_rdy=1, dma_active=0, dma_addr=0000, dma_rw=1.
- Even-aligned transfer: model RAM $0200+i = i^8'h5A. Write 8'h02 to $4014 with HALT odd -> exactly 513 cpu_ce with cpu_rdy=0. Required: 256 writes to $2004 with data i^5A in order, reads at $0200..$02FF, cpu_rdy=1 on the 514th edge.
- Misaligned transfer: same stimulus one CPU cycle later -> ALIGN inserted, 514 halted cycles, identical OAM byte sequence.
- Non-trigger accesses: read of $4014, and write of 8'h03 to $4015 -> cpu_rdy stays 1, dma_active stays 0.
- Reset mid-operation: assert rst after 100 bytes, at idx=8'h64 -> same clk outputs at reset values, state IDLE. A new write of 8'h07 to $4014 then copies $0700-$07FF starting at idx 0.
- cpu_ce gating: cpu_ce=1 every 12th clk during a transfer -> outputs stable between pulses, total halt length still 513/514 CPU cycles.
